// File: rtl/trisc_arb_pkg.sv
// Shared types and constants for the TRISC memory arbiter.
// State encoding, owner identifiers and default bus widths.
package trisc_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } arb_state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LDR = 1'b1;

   localparam int unsigned DEF_AW = 4;
   localparam int unsigned DEF_DW = 8;

endpackage

// File: rtl/trisc_mem_arbiter.sv
// Round-robin arbiter sharing the TRISC RAM between the CPU and the loader port.
// Optional CPU bus lock is built only when TRISC_ARB_LOCK_EN is defined.
module trisc_mem_arbiter
   import trisc_arb_pkg::*;
#(
   parameter int unsigned AW       = DEF_AW,
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          CLR_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_lock,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_done,
   output logic [DW-1:0] ldr_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   arb_state_e    state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          last_q, last_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

   logic ldr_allow;
   logic ldr_elig;
   logic grant_cpu;
   logic grant_ldr;

   // On a tie the port that did not own the previous transaction wins.
   assign ldr_elig  = ldr_req & ldr_allow;
   assign grant_cpu = cpu_req & (~ldr_elig | (last_q == OWNER_LDR));
   assign grant_ldr = ldr_elig & ~grant_cpu;

`ifdef TRISC_ARB_LOCK_EN
   localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

   logic            lock_q, lock_d;
   logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

   always_comb begin
      lock_d     = lock_q;
      idle_cnt_d = idle_cnt_q;
      if (!lock_q) begin
         idle_cnt_d = '0;
      end else if (state_q == IDLE) begin
         if (grant_cpu) begin
            idle_cnt_d = '0;
         end else if (!cpu_req) begin
            if (idle_cnt_q < CntW'(LOCK_MAX)) idle_cnt_d = idle_cnt_q + 1'b1;
            // This idle cycle is the LOCK_MAX-th in a row: release.
            if (idle_cnt_q >= CntW'(LOCK_MAX - 1)) lock_d = 1'b0;
         end
      end
      if (state_q == DONE && owner_q == OWNER_CPU) begin
         lock_d     = cpu_lock;
         idle_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         lock_q     <= 1'b0;
         idle_cnt_q <= '0;
      end else begin
         lock_q     <= lock_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign ldr_allow = ~lock_q;
`else
   logic unused_lock;

   assign unused_lock = cpu_lock ^ (LOCK_MAX == 0);
   assign ldr_allow   = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_d      = last_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_cpu) begin
               owner_d = OWNER_CPU;
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = ACC;
            end else if (grant_ldr) begin
               owner_d = OWNER_LDR;
               we_d    = ldr_we;
               addr_d  = ldr_addr;
               wdata_d = ldr_wdata;
               state_d = ACC;
            end
         end
         ACC: begin
            state_d = we_q ? DONE : XFER;
         end
         XFER: begin
            if (owner_q == OWNER_CPU) cpu_rdata_d = mem_rdata;
            else                      ldr_rdata_d = mem_rdata;
            state_d = DONE;
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         state_q     <= IDLE;
         owner_q     <= OWNER_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_q      <= OWNER_LDR;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_q      <= last_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign busy      = (state_q != IDLE);
   assign cpu_gnt   = busy & (owner_q == OWNER_CPU);
   assign ldr_gnt   = busy & (owner_q == OWNER_LDR);
   assign cpu_done  = (state_q == DONE) & (owner_q == OWNER_CPU);
   assign ldr_done  = (state_q == DONE) & (owner_q == OWNER_LDR);
   assign mem_rd    = (state_q == ACC) & ~we_q;
   assign mem_wr    = (state_q == ACC) & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Self-checking bench for trisc_mem_arbiter: directed timeline checks plus
// randomized two-port traffic against a transaction-level model.
module tb_trisc_mem_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          CLR_n;
   logic          cpu_req, cpu_we, cpu_lock;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_done;
   logic [DW-1:0] cpu_rdata;
   logic          ldr_req, ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_gnt, ldr_done;
   logic [DW-1:0] ldr_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rd, mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   always #5 clk = ~clk;

   trisc_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
      .clk(clk), .CLR_n(CLR_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_val(input int i);
      logic [7:0] k;
      k = 8'(i ^ 3);
      return 8'h5A ^ 8'(k * 8'd29);
   endfunction

   // RAM device: data one cycle after mem_rd, junk on every other cycle.
   logic [DW-1:0] ram [16];
   bit            ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= (mem_rd && ram_ready) ? ram[mem_addr] : 8'($urandom);
   end

   // Transaction-level model: a granted access occupies cycles 1..lat after
   // its grant cycle, lat = 2 for writes and 3 for reads.
   logic [7:0] mram [16];
   bit         m_ready = 1'b0;
   bit         chk_en  = 1'b1;
   bit         m_active;
   logic       m_owner, m_we, m_last;
   logic [3:0] m_addr;
   logic [7:0] m_wdata;
   logic [7:0] m_rd [2];
   int         m_k;

   always @(negedge clk or negedge CLR_n) begin
      int lat;
      if (!m_ready) begin
         for (int i = 0; i < 16; i++) mram[i] = init_val(i);
         m_ready = 1'b1;
      end
      if (!CLR_n) begin
         m_active = 1'b0;
         m_last   = 1'b1;
         m_rd[0]  = 8'h00;
         m_rd[1]  = 8'h00;
      end else if (chk_en) begin
         lat = m_we ? 2 : 3;
         check("busy", busy, m_active);
         check("cpu_gnt", cpu_gnt, m_active && m_owner == 1'b0);
         check("ldr_gnt", ldr_gnt, m_active && m_owner == 1'b1);
         check("cpu_done", cpu_done, m_active && m_owner == 1'b0 && m_k == lat);
         check("ldr_done", ldr_done, m_active && m_owner == 1'b1 && m_k == lat);
         check("mem_rd", mem_rd, m_active && m_k == 1 && !m_we);
         check("mem_wr", mem_wr, m_active && m_k == 1 && m_we);
         check("cpu_rdata", cpu_rdata, m_rd[0]);
         check("ldr_rdata", ldr_rdata, m_rd[1]);
         if (m_active && m_k == 1) begin
            check("mem_addr", mem_addr, m_addr);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
         end
         if (m_active) begin
            if (m_k == 1 && m_we) mram[m_addr] = m_wdata;
            if (m_k == 2 && !m_we) m_rd[m_owner] = mram[m_addr];
            if (m_k == lat) begin
               m_active = 1'b0;
               m_last   = m_owner;
            end
            m_k++;
         end else if (cpu_req || ldr_req) begin
            m_owner  = (cpu_req && ldr_req) ? ~m_last : ~cpu_req;
            m_we     = m_owner ? ldr_we : cpu_we;
            m_addr   = m_owner ? ldr_addr : cpu_addr;
            m_wdata  = m_owner ? ldr_wdata : cpu_wdata;
            m_active = 1'b1;
            m_k      = 1;
         end
      end
   end

   task automatic do_reset();
      CLR_n = 1'b0;
      @(posedge clk);
      #1 CLR_n = 1'b1;
   endtask

   task automatic wait_done(input bit p, input string name);
      bit got = 1'b0;
      int n   = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         got = p ? ldr_done : cpu_done;
         n++;
      end
      check(name, got, 1'b1);
   endtask

   task automatic run_port(input bit p, input int n);
      int gap;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(posedge clk);
         if (gap > 0) #1;
         if (!p) begin
            cpu_we    = 1'($urandom);
            cpu_addr  = 4'($urandom);
            cpu_wdata = 8'($urandom);
`ifndef TRISC_ARB_LOCK_EN
            cpu_lock  = 1'($urandom);
`endif
            cpu_req   = 1'b1;
         end else begin
            ldr_we    = 1'($urandom);
            ldr_addr  = 4'($urandom);
            ldr_wdata = 8'($urandom);
            ldr_req   = 1'b1;
         end
         wait_done(p, p ? "ldr done seen" : "cpu done seen");
         @(posedge clk);
         #1;
         if (!p) cpu_req = 1'b0;
         else    ldr_req = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic order [6];
      int   n_ord, ncd, nld;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_lock = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      CLR_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst gnt", {cpu_gnt, ldr_gnt}, 0);
      check("rst done", {cpu_done, ldr_done}, 0);
      check("rst strobes", {mem_rd, mem_wr}, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst rdata", {cpu_rdata, ldr_rdata}, 0);
      CLR_n = 1'b1;

      // Reset in the XFER cycle of a CPU read: abort, no done, rdata untouched.
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 3;
      @(posedge clk); @(posedge clk); #1;
      check("xfer busy", busy, 1);
      CLR_n = 1'b0; cpu_req = 0;
      #1;
      check("abort busy", busy, 0);
      check("abort gnt", cpu_gnt, 0);
      check("abort strobes", {mem_rd, mem_wr}, 0);
      #1 CLR_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort no done", cpu_done, 0);
      end
      check("abort rdata", cpu_rdata, 8'h00);

      // CPU read of addr 3, literal cycle timeline.
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 3;
      @(negedge clk);
      check("rd t gnt", cpu_gnt, 0);
      @(negedge clk);
      check("rd t+1 gnt", cpu_gnt, 1);
      check("rd t+1 mem_rd", mem_rd, 1);
      check("rd t+1 addr", mem_addr, 3);
      @(negedge clk);
      check("rd t+2 gnt/rd/done", {cpu_gnt, mem_rd, cpu_done}, 3'b100);
      @(negedge clk);
      check("rd t+3 done", cpu_done, 1);
      check("rd t+3 rdata", cpu_rdata, 8'h5A);
      check("rd ldr quiet", {ldr_gnt, ldr_done, ldr_rdata}, 0);
      @(posedge clk); #1 cpu_req = 0;

      // Loader write addr 7 = C3, then CPU read of addr 7.
      @(posedge clk); #1;
      ldr_req = 1; ldr_we = 1; ldr_addr = 7; ldr_wdata = 8'hC3;
      @(negedge clk);
      @(negedge clk);
      check("wr t+1 mem_wr", {mem_wr, mem_rd}, 2'b10);
      check("wr t+1 addr/data", {mem_addr, mem_wdata}, {4'd7, 8'hC3});
      @(negedge clk);
      check("wr t+2 done", {ldr_done, mem_wr}, 2'b10);
      @(posedge clk); #1;
      ldr_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 7;
      repeat (4) @(negedge clk);
      check("rd7 done", cpu_done, 1);
      check("rd7 rdata", cpu_rdata, 8'hC3);
      check("rd7 ldr_rdata", ldr_rdata, 8'h00);
      @(posedge clk); #1 cpu_req = 0;

      // Simultaneous requests held through three transactions each.
      @(posedge clk); #1;
      do_reset();
      cpu_we = 0; cpu_addr = 3;
      ldr_we = 1; ldr_addr = 9; ldr_wdata = 8'h96;
      cpu_req = 1; ldr_req = 1;
      n_ord = 0; ncd = 0; nld = 0;
      for (int i = 0; i < 40 && (ncd < 3 || nld < 3); i++) begin
         @(negedge clk);
         if (cpu_done) begin
            if (n_ord < 6) order[n_ord] = 1'b0;
            n_ord++; ncd++;
         end
         if (ldr_done) begin
            if (n_ord < 6) order[n_ord] = 1'b1;
            n_ord++; nld++;
         end
         @(posedge clk); #1;
         if (ncd >= 3) cpu_req = 0;
         if (nld >= 3) ldr_req = 0;
      end
      cpu_req = 0; ldr_req = 0;
      check("rr count", n_ord, 6);
      for (int i = 0; i < 6 && i < n_ord; i++) check($sformatf("rr order %0d", i), order[i], i % 2);

      // Randomized traffic on both ports.
      @(posedge clk); #1;
      fork
         run_port(1'b0, 60);
         run_port(1'b1, 60);
      join
      repeat (3) @(posedge clk);
      #1;

`ifdef TRISC_ARB_LOCK_EN
      chk_en = 1'b0;
      cpu_lock = 0;
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 3; cpu_lock = 1;
      @(posedge clk); #1;
      ldr_req = 1; ldr_we = 0; ldr_addr = 5;
      wait_done(1'b0, "lock rd done");
      @(posedge clk); #1;
      cpu_we = 1; cpu_addr = 4; cpu_wdata = 8'h77; cpu_lock = 0;
      begin
         bit got = 1'b0;
         bit lg  = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cpu_done;
            lg  = lg | ldr_gnt;
         end
         check("lock wr done", got, 1);
         check("locked ldr gnt", lg, 0);
      end
      @(posedge clk); #1 cpu_req = 0;
      @(negedge clk);
      @(negedge clk);
      check("unlock ldr gnt", ldr_gnt, 1);
      wait_done(1'b1, "unlock ldr done");
      @(posedge clk); #1 ldr_req = 0;

      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 2; cpu_lock = 1;
      wait_done(1'b0, "expire rd done");
      @(posedge clk); #1;
      cpu_req = 0; cpu_lock = 0;
      ldr_req = 1; ldr_we = 0; ldr_addr = 1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("expire held %0d", i), ldr_gnt, 0);
      end
      @(negedge clk);
      check("expire ldr gnt", ldr_gnt, 1);
      wait_done(1'b1, "expire ldr done");
      @(posedge clk); #1 ldr_req = 0;
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
